// File: rtl/mouse_ctrl_pkg.sv
// Shared types and constants for the PS/2 mouse cursor controller.
// Holds the sequencer state enum, default resolution and clamp width helper.
package mouse_ctrl_pkg;

  typedef enum logic [1:0] {
    RESET,
    INIT,
    RUN
  } state_e;

  localparam int DEF_H_RES = 640;
  localparam int DEF_V_RES = 480;
  localparam int ACCEL_THR = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Signed width that holds cursor + any sign-extended delta without overflow.
  function automatic int clamp_w(input int acc_bits, input int res);
    return max2(acc_bits, $clog2(res)) + 2;
  endfunction

endpackage

// File: rtl/cursor_axis_clamp.sv
// One cursor axis: modular delta, sign extend, add, clamp to [0, limit-1].
// MOUSE_ACCEL_EN doubles deltas whose magnitude exceeds the threshold.
module cursor_axis_clamp
  import mouse_ctrl_pkg::*;
#(
  parameter int c_acc_bits = 11,
  parameter int c_limit = DEF_H_RES,
  localparam int CW = $clog2(c_limit),
  localparam int SW = clamp_w(c_acc_bits, c_limit)
) (
  input  logic [c_acc_bits-1:0] i_acc,
  input  logic [c_acc_bits-1:0] i_prev,
  input  logic [CW-1:0]         i_cur,
  output logic [CW-1:0]         o_next
);

  logic [c_acc_bits-1:0] w_delta;
  logic signed [SW-1:0]  w_dext;
  logic signed [SW-1:0]  w_dacc;
  logic signed [SW-1:0]  w_cur;
  logic signed [SW-1:0]  w_sum;

  assign w_delta = i_acc - i_prev;
  assign w_dext  = {{(SW-c_acc_bits){w_delta[c_acc_bits-1]}}, w_delta};

`ifdef MOUSE_ACCEL_EN
  logic signed [SW-1:0] w_abs;
  assign w_abs  = (w_dext < 0) ? -w_dext : w_dext;
  assign w_dacc = (w_abs > $signed(SW'(ACCEL_THR))) ? (w_dext <<< 1) : w_dext;
`else
  assign w_dacc = w_dext;
`endif

  assign w_cur = {{(SW-CW){1'b0}}, i_cur};
  assign w_sum = w_cur + w_dacc;

  always_comb begin
    o_next = w_sum[CW-1:0];
    if (w_sum < 0)
      o_next = '0;
    else if (w_sum > $signed(SW'(c_limit - 1)))
      o_next = CW'(c_limit - 1);
  end

endmodule

// File: rtl/ps2_mouse_cursor_ctrl.sv
// PS/2 mouse init sequencer and clamped cursor / saturating wheel engine.
// Optional MOUSE_ACCEL_EN enables 2x acceleration of large x/y deltas.
module ps2_mouse_cursor_ctrl
  import mouse_ctrl_pkg::*;
#(
  parameter int c_x_bits = 11,
  parameter int c_y_bits = 11,
  parameter int c_z_bits = 11,
  parameter int c_h_res = DEF_H_RES,
  parameter int c_v_res = DEF_V_RES,
  parameter int c_wheel_bits = 8,
  parameter int c_rst_cycles = 25000,
  parameter int c_init_to = 12500000,
  parameter int c_init_acks = 7,
  parameter int c_max_retry = 3,
  localparam int XW = $clog2(c_h_res),
  localparam int YW = $clog2(c_v_res)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    reinit,
  input  logic                    m_update,
  input  logic [c_x_bits-1:0]     m_x,
  input  logic [c_y_bits-1:0]     m_y,
  input  logic [c_z_bits-1:0]     m_z,
  input  logic [2:0]              m_btn,
  output logic                    ps2m_reset,
  output logic                    ready,
  output logic                    fail,
  output logic [XW-1:0]           cursor_x,
  output logic [YW-1:0]           cursor_y,
  output logic [c_wheel_bits-1:0] wheel,
  output logic [2:0]              btn,
  output logic                    cur_valid
);

  localparam int TW = $clog2(max2(c_rst_cycles, c_init_to) + 1);
  localparam int AW = $clog2(c_init_acks + 1);
  localparam int RW = $clog2(c_max_retry + 1);
  localparam int WB = c_wheel_bits;
  localparam int ZW = max2(c_z_bits, WB) + 1;
  localparam int WMAX = 2 ** (WB - 1) - 1;
  localparam int WMIN = -(2 ** (WB - 1));

  state_e r_state, w_state_nxt;
  logic [TW-1:0] r_timer;
  logic [AW-1:0] r_acks;
  logic [RW-1:0] r_retry;
  logic          r_fail;
  logic [c_x_bits-1:0] r_prev_x;
  logic [c_y_bits-1:0] r_prev_y;
  logic [c_z_bits-1:0] r_prev_z;
  logic [XW-1:0] r_cx;
  logic [YW-1:0] r_cy;
  logic [WB-1:0] r_wheel;
  logic [2:0]    r_btn;
  logic          r_valid;

  logic w_upd, w_rst_done, w_ack_done, w_timeout, w_run_upd;
  logic [XW-1:0] w_cx_nxt;
  logic [YW-1:0] w_cy_nxt;
  logic [c_z_bits-1:0] w_dz_raw;
  logic signed [ZW-1:0] w_wsum;
  logic [WB-1:0] w_wheel_nxt;

  // reinit takes priority; a coincident update is dropped.
  assign w_upd      = m_update & ~reinit;
  assign w_rst_done = (r_state == RESET) && (r_timer == TW'(c_rst_cycles - 1));
  assign w_ack_done = (r_state == INIT) && w_upd &&
                      (r_acks == AW'(c_init_acks - 1));
  assign w_timeout  = (r_state == INIT) && !w_upd &&
                      (r_timer == TW'(c_init_to - 1));
  assign w_run_upd  = (r_state == RUN) && w_upd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= RESET;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (reinit)
      w_state_nxt = RESET;
    else
      unique case (r_state)
        RESET: if (w_rst_done) w_state_nxt = INIT;
        INIT: begin
          if (w_ack_done)
            w_state_nxt = RUN;
          else if (w_timeout)
            w_state_nxt = RESET;
        end
        RUN: w_state_nxt = RUN;
        default: w_state_nxt = RESET;
      endcase
  end

  always_comb begin
    ps2m_reset = (r_state == RESET);
    ready      = (r_state == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
      r_acks  <= '0;
    end else if (reinit || r_state == RUN) begin
      r_timer <= '0;
      r_acks  <= '0;
    end else if (r_state == RESET) begin
      r_timer <= w_rst_done ? '0 : r_timer + TW'(1);
      r_acks  <= '0;
    end else begin
      r_timer <= (w_upd || w_timeout) ? '0 : r_timer + TW'(1);
      if (w_timeout || w_ack_done)
        r_acks <= '0;
      else if (w_upd)
        r_acks <= r_acks + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retry <= '0;
      r_fail  <= 1'b0;
    end else if (reinit) begin
      r_retry <= '0;
      r_fail  <= 1'b0;
    end else if (w_timeout) begin
      if (r_retry != RW'(c_max_retry))
        r_retry <= r_retry + RW'(1);
      if (r_retry >= RW'(c_max_retry - 1))
        r_fail <= 1'b1;
    end
  end

  cursor_axis_clamp #(
    .c_acc_bits(c_x_bits),
    .c_limit   (c_h_res)
  ) u_x (
    .i_acc (m_x),
    .i_prev(r_prev_x),
    .i_cur (r_cx),
    .o_next(w_cx_nxt)
  );

  cursor_axis_clamp #(
    .c_acc_bits(c_y_bits),
    .c_limit   (c_v_res)
  ) u_y (
    .i_acc (m_y),
    .i_prev(r_prev_y),
    .i_cur (r_cy),
    .o_next(w_cy_nxt)
  );

  assign w_dz_raw = m_z - r_prev_z;
  assign w_wsum = {{(ZW-WB){r_wheel[WB-1]}}, r_wheel} +
                  {{(ZW-c_z_bits){w_dz_raw[c_z_bits-1]}}, w_dz_raw};

  always_comb begin
    w_wheel_nxt = w_wsum[WB-1:0];
    if (w_wsum > $signed(ZW'(WMAX)))
      w_wheel_nxt = WB'(WMAX);
    else if (w_wsum < $signed(ZW'(WMIN)))
      w_wheel_nxt = WB'(WMIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_x <= '0;
      r_prev_y <= '0;
      r_prev_z <= '0;
      r_cx     <= XW'(c_h_res / 2);
      r_cy     <= YW'(c_v_res / 2);
      r_wheel  <= '0;
      r_btn    <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= w_run_upd;
      if (reinit) begin
        r_btn <= '0;
      end else if (w_ack_done) begin
        r_prev_x <= '0;
        r_prev_y <= '0;
        r_prev_z <= '0;
      end else if (w_run_upd) begin
        r_prev_x <= m_x;
        r_prev_y <= m_y;
        r_prev_z <= m_z;
        r_cx     <= w_cx_nxt;
        r_cy     <= w_cy_nxt;
        r_wheel  <= w_wheel_nxt;
        r_btn    <= m_btn;
      end
    end
  end

  assign fail      = r_fail;
  assign cursor_x  = r_cx;
  assign cursor_y  = r_cy;
  assign wheel     = r_wheel;
  assign btn       = r_btn;
  assign cur_valid = r_valid;

endmodule

// File: tb/tb_ps2_mouse_cursor_ctrl.sv
// Directed bench for ps2_mouse_cursor_ctrl with short reset/timeout params.
// Expectations follow the build's MOUSE_ACCEL_EN setting.
module tb_ps2_mouse_cursor_ctrl;

`ifdef MOUSE_ACCEL_EN
  localparam int E_T3A = 330, E_T3B = 318;
  localparam int E_V0X = 639, E_V2Y = 40, E_V7X = 639;
  localparam int E_A6 = 12, E_A3 = 15;
`else
  localparam int E_T3A = 325, E_T3B = 319;
  localparam int E_V0X = 630, E_V2Y = 140, E_V7X = 638;
  localparam int E_A6 = 6, E_A3 = 9;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic reinit = 1'b0;
  logic m_update = 1'b0;
  logic [10:0] m_x = '0, m_y = '0, m_z = '0;
  logic [2:0] m_btn = '0;
  logic ps2m_reset, ready, fail, cur_valid;
  logic [9:0] cursor_x;
  logic [8:0] cursor_y;
  logic [7:0] wheel;
  logic [2:0] btn;

  always #5 clk = ~clk;

  ps2_mouse_cursor_ctrl #(
    .c_rst_cycles(10),
    .c_init_to   (100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reinit    (reinit),
    .m_update  (m_update),
    .m_x       (m_x),
    .m_y       (m_y),
    .m_z       (m_z),
    .m_btn     (m_btn),
    .ps2m_reset(ps2m_reset),
    .ready     (ready),
    .fail      (fail),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .wheel     (wheel),
    .btn       (btn),
    .cur_valid (cur_valid)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [10:0] x, y, z;
    logic [2:0]  b;
    int cx, cy, wh, bt;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic upd(input int x, input int y, input int z, input int b);
    @(negedge clk);
    m_x = 11'(x);
    m_y = 11'(y);
    m_z = 11'(z);
    m_btn = 3'(b);
    m_update = 1'b1;
    @(negedge clk);
    m_update = 1'b0;
  endtask

  task automatic count_reset(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (ps2m_reset && n < 1000);
  endtask

  task automatic count_init(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ps2m_reset && n < 1000);
  endtask

  task automatic do_init();
    for (int i = 0; i < 7; i++) begin
      upd(0, 0, 0, 0);
      if (i == 5) chk("ready_after_6", int'(ready), 0);
    end
    chk("ready_after_7", int'(ready), 1);
  endtask

  task automatic pulse_reinit();
    @(negedge clk);
    reinit = 1'b1;
    @(negedge clk);
    reinit = 1'b0;
  endtask

  initial begin
    int n;
    tv[0] = '{11'd310,  11'd0,    11'd0,    3'd1, E_V0X, 240,   0, 1};
    tv[1] = '{11'd360,  11'd0,    11'd0,    3'd2, 639,   240,   0, 2};
    tv[2] = '{11'd360,  11'd1948, 11'd200,  3'd4, 639, E_V2Y, 127, 4};
    tv[3] = '{11'd360,  11'd1648, 11'd400,  3'd7, 639,   0,   127, 7};
    tv[4] = '{11'd361,  11'd1648, 11'd600,  3'd0, 639,   0,   127, 0};
    tv[5] = '{11'd1409, 11'd1649, 11'd300,  3'd5, 0,     1,  -128, 5};
    tv[6] = '{11'd1409, 11'd1649, 11'd400,  3'd5, 0,     1,   -28, 5};
    tv[7] = '{11'd2047, 11'd81,   11'd400,  3'd0, E_V7X, 479, -28, 0};
    tv[8] = '{11'd0,    11'd81,   11'd1448, 3'd3, 639,   479, -128, 3};
    tv[9] = '{11'd2047, 11'd81,   11'd1449, 3'd3, 638,   479, -127, 3};

    #12;
    chk("rst_ps2m_reset", int'(ps2m_reset), 1);
    chk("rst_ready", int'(ready), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_cursor_x", int'(cursor_x), 320);
    chk("rst_cursor_y", int'(cursor_y), 240);
    chk("rst_wheel", int'($signed(wheel)), 0);
    chk("rst_btn", int'(btn), 0);
    chk("rst_cur_valid", int'(cur_valid), 0);

    @(negedge clk);
    rst_n = 1'b1;
    count_reset(n);
    chk("reset_len", n, 10);
    do_init();

    upd(5, 0, 0, 0);
    chk("t3_x_plus5", int'(cursor_x), E_T3A);
    chk("t3_valid_pulse", int'(cur_valid), 1);
    @(negedge clk);
    chk("t3_valid_drop", int'(cur_valid), 0);
    upd(2047, 0, 0, 0);
    chk("t3_x_wrap", int'(cursor_x), E_T3B);

    // back-to-back updates, one per cycle
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      m_x = tv[i].x;
      m_y = tv[i].y;
      m_z = tv[i].z;
      m_btn = tv[i].b;
      m_update = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_cx", i), int'(cursor_x), tv[i].cx);
      chk($sformatf("v%0d_cy", i), int'(cursor_y), tv[i].cy);
      chk($sformatf("v%0d_wheel", i), int'($signed(wheel)), tv[i].wh);
      chk($sformatf("v%0d_btn", i), int'(btn), tv[i].bt);
      chk($sformatf("v%0d_valid", i), int'(cur_valid), 1);
    end
    m_update = 1'b0;

    // reinit beats a same-cycle update
    @(negedge clk);
    reinit = 1'b1;
    m_update = 1'b1;
    m_x = 11'd100;
    @(negedge clk);
    reinit = 1'b0;
    m_update = 1'b0;
    chk("ri_cursor_x", int'(cursor_x), 638);
    chk("ri_cursor_y", int'(cursor_y), 479);
    chk("ri_wheel", int'($signed(wheel)), -127);
    chk("ri_btn", int'(btn), 0);
    chk("ri_valid", int'(cur_valid), 0);
    chk("ri_ps2m_reset", int'(ps2m_reset), 1);
    chk("ri_ready", int'(ready), 0);
    count_reset(n);
    chk("ri_reset_len", n, 10);
    do_init();

    upd(1047, 0, 0, 0);
    chk("acc_to_zero", int'(cursor_x), 0);
    chk("acc_wheel_kept", int'($signed(wheel)), -127);
    upd(1053, 0, 0, 0);
    chk("acc_dx6", int'(cursor_x), E_A6);
    upd(1056, 0, 0, 0);
    chk("acc_dx3", int'(cursor_x), E_A3);

    // init timeout and retry exhaustion
    pulse_reinit();
    count_reset(n);
    chk("to_reset_len", n, 10);
    for (int t = 0; t < 3; t++) begin
      count_init(n);
      chk($sformatf("to%0d_len", t), n, 100);
      chk($sformatf("to%0d_fail", t), int'(fail), (t == 2) ? 1 : 0);
      count_reset(n);
    end
    chk("to_fail_sticky", int'(fail), 1);
    pulse_reinit();
    chk("to_reinit_fail", int'(fail), 0);
    chk("to_reinit_rst", int'(ps2m_reset), 1);

    // asynchronous reset mid-operation
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_cursor_x", int'(cursor_x), 320);
    chk("ar_cursor_y", int'(cursor_y), 240);
    chk("ar_wheel", int'($signed(wheel)), 0);
    chk("ar_ps2m_reset", int'(ps2m_reset), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
